// File: rtl/uart_rx_dma.sv
// uart_rx_dma: buffers bytes from the UART receiver in a small FIFO and writes
// each one, as a Wishbone master, into a ring buffer region of data memory.
// Bus ownership is negotiated with an external arbiter through bus_req/bus_gnt.
module uart_rx_dma #(
    parameter logic [7:0]  BASE_ADR   = 8'hC0,
    parameter int unsigned BUF_LEN    = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       rx_valid_i,
    input  logic [7:0]                 rx_data_i,
    input  logic                       clr_i,
    output logic                       bus_req_o,
    input  logic                       bus_gnt_i,
    output logic                       cyc_o,
    output logic                       stb_o,
    output logic                       we_o,
    output logic [7:0]                 adr_o,
    output logic [7:0]                 dat_o,
    input  logic                       ack_i,
    output logic [$clog2(BUF_LEN)-1:0] wr_ptr_o,
    output logic                       ovf_o
);
    localparam int unsigned PTR_W   = $clog2(BUF_LEN);
    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_BUS  = 2'b10
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         fifo_mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0] fifo_rd_idx_r;
    logic [FIFO_AW-1:0] fifo_wr_idx_r;
    logic [CNT_W-1:0]   fifo_cnt_r;
    logic [CNT_W-1:0]   fifo_cnt_nxt_s;
    logic [7:0]         fifo_head_s;
    logic               fifo_full_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;

    // FSM and registered outputs
    state_t             state_r;
    state_t             state_nxt_s;
    logic               bus_req_r,   bus_req_nxt_s;
    logic               cyc_r,       cyc_nxt_s;
    logic [7:0]         adr_r,       adr_nxt_s;
    logic [7:0]         dat_r,       dat_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r,    wr_ptr_nxt_s;
    logic               ovf_r,       ovf_nxt_s;
    // A clear seen during a bus cycle turns its ack into a no-op (no pop, no ptr step)
    logic               clr_pend_r,  clr_pend_nxt_s;

    assign fifo_head_s = fifo_mem_r[fifo_rd_idx_r];
    assign fifo_full_s = (fifo_cnt_r == CNT_W'(FIFO_DEPTH));

    // FIFO push/pop/drop decisions; a pop frees the slot a same-cycle push needs
    always_comb begin
        pop_s  = (state_r == ST_BUS) && ack_i && !clr_pend_r && !clr_i;
        push_s = rx_valid_i && !clr_i && (!fifo_full_s || pop_s);
        drop_s = rx_valid_i && !clr_i && fifo_full_s && !pop_s;
        if (clr_i) begin
            fifo_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (push_s && !pop_s) begin
            fifo_cnt_nxt_s = fifo_cnt_r + CNT_W'(1'b1);
        end else if (pop_s && !push_s) begin
            fifo_cnt_nxt_s = fifo_cnt_r - CNT_W'(1'b1);
        end else begin
            fifo_cnt_nxt_s = fifo_cnt_r;
        end
    end

    // FIFO data storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
        end else if (push_s) begin
            fifo_mem_r[fifo_wr_idx_r] <= rx_data_i;
        end
    end

    // FIFO read/write indices and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_rd_idx_r <= {FIFO_AW{1'b0}};
            fifo_wr_idx_r <= {FIFO_AW{1'b0}};
            fifo_cnt_r    <= {CNT_W{1'b0}};
        end else if (clr_i) begin
            fifo_rd_idx_r <= {FIFO_AW{1'b0}};
            fifo_wr_idx_r <= {FIFO_AW{1'b0}};
            fifo_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_wr_idx_r <= fifo_wr_idx_r + FIFO_AW'(1'b1);
            end
            if (pop_s) begin
                fifo_rd_idx_r <= fifo_rd_idx_r + FIFO_AW'(1'b1);
            end
            fifo_cnt_r <= fifo_cnt_nxt_s;
        end
    end

    // Next-state and next-output logic for the bus master FSM
    always_comb begin
        state_nxt_s    = state_r;
        bus_req_nxt_s  = bus_req_r;
        cyc_nxt_s      = cyc_r;
        adr_nxt_s      = adr_r;
        dat_nxt_s      = dat_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        ovf_nxt_s      = ovf_r | drop_s;
        clr_pend_nxt_s = clr_pend_r;
        case (state_r)
            ST_IDLE: begin
                if (!clr_i && (fifo_cnt_r != {CNT_W{1'b0}})) begin
                    state_nxt_s   = ST_REQ;
                    bus_req_nxt_s = 1'b1;
                end else begin
                    state_nxt_s   = ST_IDLE;
                    bus_req_nxt_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (clr_i) begin
                    state_nxt_s   = ST_IDLE;
                    bus_req_nxt_s = 1'b0;
                end else if (bus_gnt_i) begin
                    state_nxt_s   = ST_BUS;
                    bus_req_nxt_s = 1'b1;
                    cyc_nxt_s     = 1'b1;
                    adr_nxt_s     = BASE_ADR + 8'(wr_ptr_r);
                    dat_nxt_s     = fifo_head_s;
                end else begin
                    state_nxt_s   = ST_REQ;
                    bus_req_nxt_s = 1'b1;
                end
            end
            ST_BUS: begin
                if (ack_i) begin
                    cyc_nxt_s = 1'b0;
                    if (clr_i || clr_pend_r) begin
                        // Cycle cleared while in flight: finish it and go quiet
                        state_nxt_s    = ST_IDLE;
                        bus_req_nxt_s  = 1'b0;
                        clr_pend_nxt_s = 1'b0;
                    end else begin
                        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
                        if (fifo_cnt_nxt_s != {CNT_W{1'b0}}) begin
                            state_nxt_s   = ST_REQ;
                            bus_req_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s   = ST_IDLE;
                            bus_req_nxt_s = 1'b0;
                        end
                    end
                end else if (clr_i) begin
                    clr_pend_nxt_s = 1'b1;
                end else begin
                    clr_pend_nxt_s = clr_pend_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                bus_req_nxt_s  = 1'b0;
                cyc_nxt_s      = 1'b0;
                clr_pend_nxt_s = 1'b0;
            end
        endcase
        // Clear resets the ring position and the sticky overflow in any state
        if (clr_i) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            ovf_nxt_s    = 1'b0;
        end else begin
            ovf_nxt_s    = ovf_nxt_s;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            bus_req_r  <= 1'b0;
            cyc_r      <= 1'b0;
            adr_r      <= 8'h00;
            dat_r      <= 8'h00;
            wr_ptr_r   <= {PTR_W{1'b0}};
            ovf_r      <= 1'b0;
            clr_pend_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            bus_req_r  <= bus_req_nxt_s;
            cyc_r      <= cyc_nxt_s;
            adr_r      <= adr_nxt_s;
            dat_r      <= dat_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            ovf_r      <= ovf_nxt_s;
            clr_pend_r <= clr_pend_nxt_s;
        end
    end

    assign bus_req_o = bus_req_r;
    assign cyc_o     = cyc_r;
    assign stb_o     = cyc_r;
    assign we_o      = cyc_r;
    assign adr_o     = adr_r;
    assign dat_o     = dat_r;
    assign wr_ptr_o  = wr_ptr_r;
    assign ovf_o     = ovf_r;

endmodule

// File: tb/tb_uart_rx_dma.sv
// Self-checking bench for uart_rx_dma: directed scenarios plus a randomized
// byte stream compared against a ring-buffer reference model.
module tb_uart_rx_dma;
    localparam logic [7:0] BASE = 8'hC0;
    localparam int         BLEN = 32;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       clr = 1'b0;
    logic       bus_req;
    logic       bus_gnt = 1'b0;
    logic       cyc, stb, we;
    logic [7:0] adr, dat;
    logic       ack;
    logic [4:0] wr_ptr;
    logic       ovf;

    int ack_wait = 0;
    int wait_cnt = 0;
    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [15:0] wr_log [$];
    logic [15:0] exp_q  [$];

    uart_rx_dma #(.BASE_ADR(8'hC0), .BUF_LEN(32), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .clr_i(clr), .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .cyc_o(cyc),
        .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat), .ack_i(ack),
        .wr_ptr_o(wr_ptr), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    // Memory slave: ack after ack_wait wait states, combinational from stb
    assign ack = stb && (wait_cnt >= ack_wait);

    always @(posedge clk) begin
        if (!stb || ack) wait_cnt <= 0;
        else             wait_cnt <= wait_cnt + 1;
        if (cyc && stb && we && ack) wr_log.push_back({adr, dat});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] d;
        int ptr_m;
        int gap;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_cyc", cyc, 1'b0);
        check("rst_stb", stb, 1'b0);
        check("rst_we", we, 1'b0);
        check("rst_adr", adr, 8'h00);
        check("rst_dat", dat, 8'h00);
        check("rst_ptr", wr_ptr, 5'd0);
        check("rst_ovf", ovf, 1'b0);
        rst_ni = 1'b1;
        tick();

        // ---- single byte, grant tied high, combinational ack ----
        bus_gnt = 1'b1;
        rx_valid = 1'b1; rx_data = 8'hA5;
        tick();                                   // cycle 1
        rx_valid = 1'b0;
        check("single_c1_req", bus_req, 1'b0);
        tick();                                   // cycle 2
        check("single_c2_req", {bus_req, cyc}, 2'b10);
        tick();                                   // cycle 3
        check("single_c3_ctl", {cyc, stb, we}, 3'b111);
        check("single_c3_adr", adr, 8'hC0);
        check("single_c3_dat", dat, 8'hA5);
        tick();                                   // cycle 4
        check("single_c4_ptr", wr_ptr, 5'd1);
        check("single_c4_req", {bus_req, cyc}, 2'b00);
        check("single_log_n", wr_log.size(), 1);
        if (wr_log.size() > 0) check("single_log", wr_log[0], {8'hC0, 8'hA5});

        // ---- grant withheld for 5 cycles ----
        wr_log.delete();
        bus_gnt = 1'b0;
        d = 8'($urandom);
        rx_valid = 1'b1; rx_data = d;
        tick();
        rx_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("gnt_wait_req", {bus_req, cyc}, 2'b10);
            tick();
        end
        check("gnt_wait_last", {bus_req, cyc}, 2'b10);
        bus_gnt = 1'b1;
        tick();
        check("gnt_cyc", cyc, 1'b1);
        check("gnt_adr", adr, BASE + 8'd1);
        check("gnt_dat", dat, d);
        tick();
        check("gnt_ptr", wr_ptr, 5'd2);
        check("gnt_log", (wr_log.size() == 1) ? wr_log[0] : 16'hxxxx, {BASE + 8'd1, d});

        // ---- burst of 33 bytes across the ring wrap ----
        clr = 1'b1; tick(); clr = 1'b0;
        wr_log.delete();
        for (int i = 0; i <= 32; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            tick();
            rx_valid = 1'b0;
            tick();
        end
        repeat (8) tick();
        check("burst_n", wr_log.size(), 33);
        for (int i = 0; i < wr_log.size() && i <= 32; i++) begin
            check("burst_wr", wr_log[i], {BASE + 8'(i % BLEN), 8'(i)});
        end
        check("burst_ptr", wr_ptr, 5'd1);
        check("burst_ovf", ovf, 1'b0);

        // ---- overflow with grant held low ----
        clr = 1'b1; tick(); clr = 1'b0;
        wr_log.delete();
        bus_gnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1; rx_data = 8'h10 + 8'(i);
            tick();
            if (i == 3) check("ovf_after4", ovf, 1'b0);
            if (i == 4) check("ovf_after5", ovf, 1'b1);
        end
        rx_valid = 1'b0;
        bus_gnt = 1'b1;
        repeat (12) tick();
        check("ovf_n", wr_log.size(), 4);
        for (int i = 0; i < wr_log.size() && i < 4; i++) begin
            check("ovf_wr", wr_log[i], {BASE + 8'(i), 8'h10 + 8'(i)});
        end
        check("ovf_sticky", ovf, 1'b1);
        check("ovf_ptr", wr_ptr, 5'd4);

        // ---- clear during a 2-wait-state bus cycle ----
        wr_log.delete();
        ack_wait = 2;
        d = 8'($urandom);
        rx_valid = 1'b1; rx_data = d;
        tick();
        rx_data = ~d;                             // second byte stays queued
        tick();
        rx_valid = 1'b0;
        tick();                                   // cycle 3: first BUS cycle
        check("clr_bus_cyc", cyc, 1'b1);
        check("clr_bus_adr", adr, BASE + 8'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_hold_cyc", {cyc, adr, dat}, {1'b1, BASE + 8'd4, d});
        check("clr_ptr0", wr_ptr, 5'd0);
        check("clr_ovf0", ovf, 1'b0);
        tick();
        check("clr_wait_cyc", cyc, 1'b1);
        tick();
        check("clr_done", {cyc, bus_req, wr_ptr, ovf}, 8'h00);
        check("clr_log", (wr_log.size() == 1) ? wr_log[0] : 16'hxxxx, {BASE + 8'd4, d});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("clr_idle", {cyc, bus_req}, 2'b00);
        end
        check("clr_log_n", wr_log.size(), 1);

        // ---- randomized stream against the ring-buffer model ----
        wr_log.delete();
        exp_q.delete();
        ack_wait = int'($urandom_range(0, 2));
        ptr_m = 0;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            rx_valid = 1'b1; rx_data = d;
            exp_q.push_back({BASE + 8'(ptr_m), d});
            ptr_m = (ptr_m + 1) % BLEN;
            tick();
            rx_valid = 1'b0;
            gap = int'($urandom_range(1 + ack_wait, 4 + ack_wait));
            repeat (gap) tick();
        end
        repeat (12) tick();
        check("rand_n", wr_log.size(), exp_q.size());
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            check("rand_wr", wr_log[i], exp_q[i]);
        end
        check("rand_ptr", wr_ptr, 32'(ptr_m));
        check("rand_ovf", ovf, 1'b0);

        // ---- asynchronous reset during a bus cycle ----
        ack_wait = 0;
        bus_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_data = 8'($urandom);
            tick();
        end
        rx_valid = 1'b0;
        check("ar_ovf_set", ovf, 1'b1);
        ack_wait = 8;
        bus_gnt = 1'b1;
        for (int i = 0; i < 10 && !cyc; i++) tick();
        check("ar_cyc_up", cyc, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_async", {cyc, stb, bus_req, wr_ptr, ovf}, 9'h000);
        tick();
        #2;
        rst_ni = 1'b1;
        wr_log.delete();
        ack_wait = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ar_quiet", {cyc, bus_req}, 2'b00);
        end
        check("ar_no_wr", wr_log.size(), 0);
        d = 8'($urandom);
        rx_valid = 1'b1; rx_data = d;
        tick();
        rx_valid = 1'b0;
        repeat (4) tick();
        check("ar_new_wr", (wr_log.size() == 1) ? wr_log[0] : 16'hxxxx, {BASE, d});

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
